// File: rtl/pulse_period_meter_pkg.sv
// Shared constants and helpers for the pulse period meter and its siblings.
// Cycle constants are expressed in CLOCK_50 cycles.
package pulse_period_meter_pkg;

  localparam int CLK_HZ   = 50_000_000;
  localparam int CYC_1MS  = CLK_HZ / 1000;
  localparam int CYC_10MS = CLK_HZ / 100;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Bits needed to hold the value v itself, so a power of two still fits.
  function automatic int clogb2(input int v);
    int n;
    n = 0;
    for (int r = v; r > 0; r = r >> 1) begin
      n++;
    end
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// Output is a one-cycle pulse with a fixed latency from the async input.
module sync_rise_detect (
  input  logic CLOCK_50,
  input  logic aclr,
  input  logic async_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
      rise  <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/pulse_period_meter.sv
// Measures CLOCK_50 cycles between consecutive rising edges of an async input,
// strobing each result and flagging a missing or too-slow input with timeout.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter  int MAX_CYCLES = 1_000_000,
  localparam int W          = clogb2(MAX_CYCLES)
) (
  input  logic         CLOCK_50,
  input  logic         aclr,
  input  logic         enable,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         timeout,
  output logic         locked
);

  localparam logic [W-1:0] MAX_VAL = W'(MAX_CYCLES);
  localparam logic [W-1:0] ONE     = W'(1);

  logic         rise;
  state_t       state;
  state_t       state_nx;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nx;
  logic [W-1:0] period_nx;
  logic         valid_nx;
  logic         timeout_nx;
  logic         locked_nx;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] c);
    return (c >= MAX_VAL) ? MAX_VAL : c + ONE;
  endfunction

  sync_rise_detect u_sync (
    .CLOCK_50 (CLOCK_50),
    .aclr     (aclr),
    .async_in (sig_in),
    .rise     (rise)
  );

  // A rise landing on cnt==MAX_VAL is still a measurement; timeout only
  // fires when that cycle passes without an edge.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    period_nx  = period;
    valid_nx   = 1'b0;
    timeout_nx = timeout;
    locked_nx  = locked;
    if (!enable) begin
      state_nx  = IDLE;
      cnt_nx    = '0;
      locked_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nx = '0;
          if (rise) begin
            state_nx = MEASURE;
            cnt_nx   = ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_nx  = cnt;
            valid_nx   = 1'b1;
            locked_nx  = 1'b1;
            timeout_nx = 1'b0;
            cnt_nx     = ONE;
          end else if (cnt == MAX_VAL) begin
            timeout_nx = 1'b1;
            locked_nx  = 1'b0;
            cnt_nx     = '0;
            state_nx   = IDLE;
          end else begin
            cnt_nx = sat_inc(cnt);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      period  <= period_nx;
      valid   <= valid_nx;
      timeout <= timeout_nx;
      locked  <= locked_nx;
    end
  end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Receive-side companion to the team's periodic tick/pulse generators.
- Takes an asynchronous periodic input, synchronises it to CLOCK_50 and measures the number of clock cycles between consecutive rising edges.
- Publishes each measurement with a one-cycle valid strobe, and flags a missing or too-slow input with a timeout.
- Used to check delay/tick outputs on-chip and to measure external pulse trains.

Parameters:
- MAX_CYCLES, 1_000_000, longest measurable period in CLOCK_50 cycles (20 ms at 50 MHz); must be >= 2.
- W, clogb2(MAX_CYCLES), width of the period counter and output; derived, not overridden.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, all logic on its rising edge.
- aclr  in  1  asynchronous active-low reset; 0 clears all state immediately.
- enable  in  1  measurement enable; 0 abandons any measurement in progress.
- sig_in  in  1  asynchronous pulse input being measured.
- period  out  W  last completed measurement, in CLOCK_50 cycles.
- valid  out  1  one-cycle strobe: period was updated this cycle.
- timeout  out  1  level: no rising edge within MAX_CYCLES since the last edge; sticky.
- locked  out  1  level: at least one valid measurement since the last reset, timeout or disable.

Behaviour:
- Reset (aclr=0): period=0, valid=0, timeout=0, locked=0, state=IDLE, counter=0, synchroniser flops=0.
- Synchroniser: 2-FF chain on sig_in, then a registered previous-value flop.
  - rise = sync2 & ~prev.
  - The synchroniser runs regardless of enable.
- Counter cnt (W bits):
  - Loads 1 on every rise.
  - Increments each cycle otherwise.
  - Never exceeds MAX_CYCLES.
- FSM, two states:
  - IDLE: cnt held at 0; rise -> MEASURE, cnt<=1, outputs unchanged.
  - MEASURE, rise with cnt<=MAX_CYCLES: period<=cnt, valid=1 for one cycle, locked<=1, timeout<=0, cnt<=1, stay in MEASURE.
  - MEASURE, no rise and cnt==MAX_CYCLES: timeout<=1, locked<=0, cnt<=0, -> IDLE; period is retained.
  - MEASURE, otherwise: cnt<=cnt+1.
- enable=0: synchronous abort.
  - State<=IDLE, cnt<=0, locked<=0, valid=0.
  - period and timeout are held.
  - When enable returns to 1, the first rise only arms the block; there is no measurement from it.
- Rise and enable=0 in the same cycle: enable wins and the rise is discarded.
- Edge on the exact cycle cnt==MAX_CYCLES: this is a valid measurement of MAX_CYCLES, with no timeout.
- Minimum measurable period is 2 cycles (1 high, 1 low as seen after synchronisation). Shorter glitches are undefined.
- Latency: valid asserts 3 CLOCK_50 edges after the edge at which sync1 first samples 1. The latency is constant, so measured periods are exact.
- Outputs period, valid, timeout and locked are all registered.
- Reset mid-measurement: everything clears asynchronously and the block restarts in IDLE.

Decomposition:
- Shared package holds:
  - the clogb2 function;
  - CLK_HZ=50_000_000;
  - derived cycle constants CYC_1MS=50_000 and CYC_10MS=500_000.
- Sub-module sync_rise_detect (CLOCK_50, aclr, async_in -> rise) holds the 2-FF synchroniser and edge detector, and is reusable for buttons.
- The FSM, counter and output registers live in pulse_period_meter.

Test Plan:
All scenarios use MAX_CYCLES=1000.
1. Reset, enable=1, sig_in square wave with period 100 cycles (50 high / 50 low) -> first edge gives no valid; on every following edge valid=1 for 1 cycle, period=100, locked=1, timeout=0.
2. Jitter: edges spaced 37, 2, 999, 1000 cycles -> period reports 37, 2, 999, 1000 in order; timeout stays 0.
3. Stop sig_in after one 100-cycle period -> timeout rises exactly 1000 cycles after the last cnt load; locked=0; period stays 100; the next two edges 50 cycles apart give period=50 and timeout=0.
4. Drop enable for 10 cycles mid-period, then restore with edges every 80 cycles -> no valid from the first post-enable edge; the second gives period=80; period holds its old value while disabled.
5. Assert aclr=0 mid-measurement (asynchronously, between clock edges) -> all outputs 0 immediately; after release the block behaves as in scenario 1.
6. Check valid latency: place a sig_in rising edge just before clock edge k -> valid is high in the cycle following edge k+3.
